// File: rtl/exec_unit_if.sv
// Issue/result bus between register-read, the execute stage and the memory stage.
// master drives operations and consumes results; slave is the execute stage.
interface exec_unit_if #(
  parameter int WIDTH = 64
);
  logic                   in_valid;
  logic                   in_ready;
  logic [3:0]             in_op;
  logic [3:0]             in_cc;
  logic [WIDTH-1:0]       in_a;
  logic [WIDTH-1:0]       in_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     out_result;
  logic                   out_wb;
  logic                   out_branch;
  logic [WIDTH-1:0]       out_target;
  logic [63:0]            rflags;

  modport master (
    output in_valid, in_op, in_cc, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_wb, out_branch, out_target, rflags
  );

  modport slave (
    input  in_valid, in_op, in_cc, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_wb, out_branch, out_target, rflags
  );
endinterface

// File: rtl/exec_unit.sv
// Integer execute stage: single-cycle ALU ops, multi-cycle MUL/IMUL, in-block RFLAGS
// and Jcc/JMP resolution, with valid/ready on both sides and synchronous flush.
module exec_unit #(
  parameter int WIDTH       = 64,
  parameter int MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  exec_unit_if.slave  bus
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_MOV  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_IMUL = 4'd7;
  localparam logic [3:0] OP_CMP  = 4'd8;
  localparam logic [3:0] OP_JCC  = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;
  localparam logic [3:0] LAT_M1  = 4'(MUL_LATENCY - 1);

  typedef enum logic {IDLE, MUL} state_t;

  function automatic logic even_parity8(input logic [7:0] v);
    return ~^v;
  endfunction

  // x86 condition nibble: cc[3:1] selects the predicate, cc[0] negates it
  function automatic logic cond_taken(input logic [3:0] cc, input logic cf, input logic pf,
                                      input logic zf, input logic sf, input logic of);
    logic base;
    case (cc[3:1])
      3'd0:    base = of;
      3'd1:    base = cf;
      3'd2:    base = zf;
      3'd3:    base = cf | zf;
      3'd4:    base = sf;
      3'd5:    base = pf;
      3'd6:    base = sf ^ of;
      default: base = zf | (sf ^ of);
    endcase
    return base ^ cc[0];
  endfunction

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic                 imul_q, imul_d;
  logic                 out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0]   out_result_q, out_result_d;
  logic                 out_wb_q, out_wb_d;
  logic                 out_branch_q, out_branch_d;
  logic [WIDTH-1:0]     out_target_q, out_target_d;
  logic                 cf_q, pf_q, zf_q, sf_q, of_q;
  logic                 cf_d, pf_d, zf_d, sf_d, of_d;

  logic                 out_free, in_ready, accept, is_mul;
  logic [WIDTH:0]       sum_w, diff_w;
  logic                 add_ovf, sub_ovf;
  logic [WIDTH-1:0]     mul_a, mul_b;
  logic                 mul_signed, mul_hi_bad;
  logic signed [2*WIDTH-1:0] mul_xa, mul_xb, prod;

  logic                 w_en, w_wb, w_branch;
  logic [2*WIDTH-1:0]   w_result;
  logic [WIDTH-1:0]     w_target;
  logic                 f_en, f_cf, f_of;
  logic [WIDTH-1:0]     f_lo;

  assign out_free = !out_valid_q || bus.out_ready;
  assign in_ready = (state_q == IDLE) && out_free && !flush;
  assign accept   = bus.in_valid && in_ready;
  assign is_mul   = (bus.in_op == OP_MUL) || (bus.in_op == OP_IMUL);

  assign sum_w   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign diff_w  = {1'b0, bus.in_a} - {1'b0, bus.in_b};
  assign add_ovf = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) && (sum_w[WIDTH-1] != bus.in_a[WIDTH-1]);
  assign sub_ovf = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) && (diff_w[WIDTH-1] != bus.in_a[WIDTH-1]);

  // One multiplier: fed live operands for the single-cycle case, latched ones while in MUL
  assign mul_a      = (state_q == MUL) ? opa_q : bus.in_a;
  assign mul_b      = (state_q == MUL) ? opb_q : bus.in_b;
  assign mul_signed = (state_q == MUL) ? imul_q : (bus.in_op == OP_IMUL);
  assign mul_xa     = mul_signed ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a} : {{WIDTH{1'b0}}, mul_a};
  assign mul_xb     = mul_signed ? {{WIDTH{mul_b[WIDTH-1]}}, mul_b} : {{WIDTH{1'b0}}, mul_b};
  assign prod       = mul_xa * mul_xb;
  assign mul_hi_bad = mul_signed ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                                 : (|prod[2*WIDTH-1:WIDTH]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    imul_d   = imul_q;
    w_en     = 1'b0;
    w_wb     = 1'b0;
    w_branch = 1'b0;
    w_result = '0;
    w_target = '0;
    f_en     = 1'b0;
    f_cf     = 1'b0;
    f_of     = 1'b0;
    f_lo     = '0;
    if (state_q == IDLE) begin
      if (accept && is_mul && (MUL_LATENCY > 1)) begin
        state_d = MUL;
        cnt_d   = '0;
        opa_d   = bus.in_a;
        opb_d   = bus.in_b;
        imul_d  = (bus.in_op == OP_IMUL);
      end else if (accept) begin
        w_en = 1'b1;
        w_wb = 1'b1;
        case (bus.in_op)
          OP_ADD: begin
            w_result = {{WIDTH{1'b0}}, sum_w[WIDTH-1:0]};
            f_en = 1'b1; f_lo = sum_w[WIDTH-1:0]; f_cf = sum_w[WIDTH]; f_of = add_ovf;
          end
          OP_SUB, OP_CMP: begin
            w_result = {{WIDTH{1'b0}}, diff_w[WIDTH-1:0]};
            w_wb = (bus.in_op == OP_SUB);
            f_en = 1'b1; f_lo = diff_w[WIDTH-1:0]; f_cf = diff_w[WIDTH]; f_of = sub_ovf;
          end
          OP_AND: begin
            f_lo = bus.in_a & bus.in_b; f_en = 1'b1;
            w_result = {{WIDTH{1'b0}}, f_lo};
          end
          OP_OR: begin
            f_lo = bus.in_a | bus.in_b; f_en = 1'b1;
            w_result = {{WIDTH{1'b0}}, f_lo};
          end
          OP_XOR: begin
            f_lo = bus.in_a ^ bus.in_b; f_en = 1'b1;
            w_result = {{WIDTH{1'b0}}, f_lo};
          end
          OP_MOV: w_result = {{WIDTH{1'b0}}, bus.in_b};
          OP_MUL, OP_IMUL: begin
            w_result = prod;
            f_en = 1'b1; f_lo = prod[WIDTH-1:0]; f_cf = mul_hi_bad; f_of = mul_hi_bad;
          end
          OP_JCC: begin
            w_wb     = 1'b0;
            w_branch = cond_taken(bus.in_cc, cf_q, pf_q, zf_q, sf_q, of_q);
            w_target = bus.in_a;
          end
          OP_JMP: begin
            w_wb     = 1'b0;
            w_branch = 1'b1;
            w_target = bus.in_a;
          end
          default: w_wb = 1'b0;
        endcase
      end
    end else begin
      // MUL completes only when the result register can take the product this edge
      if (cnt_q == LAT_M1) begin
        if (out_free) begin
          state_d  = IDLE;
          cnt_d    = '0;
          w_en     = 1'b1;
          w_wb     = 1'b1;
          w_result = prod;
          f_en = 1'b1; f_lo = prod[WIDTH-1:0]; f_cf = mul_hi_bad; f_of = mul_hi_bad;
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      w_en    = 1'b0;
      f_en    = 1'b0;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_wb_d     = out_wb_q;
    out_branch_d = out_branch_q;
    out_target_d = out_target_q;
    cf_d = cf_q; pf_d = pf_q; zf_d = zf_q; sf_d = sf_q; of_d = of_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_en) begin
      out_valid_d  = 1'b1;
      out_result_d = w_result;
      out_wb_d     = w_wb;
      out_branch_d = w_branch;
      out_target_d = w_target;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (f_en) begin
      cf_d = f_cf;
      of_d = f_of;
      zf_d = ~|f_lo;
      sf_d = f_lo[WIDTH-1];
      pf_d = even_parity8(f_lo[7:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      imul_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_wb_q     <= 1'b0;
      out_branch_q <= 1'b0;
      out_target_q <= '0;
      cf_q <= 1'b0; pf_q <= 1'b0; zf_q <= 1'b0; sf_q <= 1'b0; of_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      imul_q       <= imul_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_wb_q     <= out_wb_d;
      out_branch_q <= out_branch_d;
      out_target_q <= out_target_d;
      cf_q <= cf_d; pf_q <= pf_d; zf_q <= zf_d; sf_q <= sf_d; of_q <= of_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_wb     = out_wb_q;
  assign bus.out_branch = out_branch_q;
  assign bus.out_target = out_target_q;
  assign bus.rflags     = {52'b0, of_q, 3'b000, sf_q, zf_q, 3'b000, pf_q, 1'b1, cf_q};

endmodule
